// File: rtl/usr_pkg.sv
// Shared op-codes and FSM state encoding for the universal shift engine.
package usr_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_SAR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit shift/rotate step; zero latency, no flow control.
// Returns the next register value and the bit pushed out by this step.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] cur,
  input  logic             serial_in,
  output logic [WIDTH-1:0] nxt,
  output logic             ejected
);

  always_comb begin
    nxt     = cur;
    ejected = 1'b0;
    case (op)
      OP_SHL: begin
        nxt     = {cur[WIDTH-2:0], serial_in};
        ejected = cur[WIDTH-1];
      end
      OP_SHR: begin
        nxt     = {serial_in, cur[WIDTH-1:1]};
        ejected = cur[0];
      end
      OP_ROL: begin
        nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
        ejected = cur[WIDTH-1];
      end
      OP_ROR: begin
        nxt     = {cur[0], cur[WIDTH-1:1]};
        ejected = cur[0];
      end
      OP_SAR: begin
        nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
        ejected = cur[0];
      end
      default: begin
        nxt     = cur;
        ejected = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/usr_shift_engine.sv
// Universal shift register: single-cycle LOAD/CLEAR/NOP, N-cycle shifts one bit per clock.
// cmd_ready is high only in IDLE; commands offered while busy wait until the done cycle.
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] AMT_ONE = CNT_W'(1);

  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] step_nxt;
  logic             step_ej;
  logic             accept;
  logic             is_shift_op;

  assign amt_clamped = (cmd_amount > AMT_MAX) ? AMT_MAX : cmd_amount;
  assign accept      = cmd_valid && (state == ST_IDLE);
  assign is_shift_op = (cmd_op != OP_NOP) && (cmd_op != OP_LOAD) && (cmd_op != OP_CLEAR);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .cur       (data),
    .serial_in (serial_in),
    .nxt       (step_nxt),
    .ejected   (step_ej)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_NOP;
      remaining  <= '0;
      data       <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift_op && (amt_clamped != '0)) begin
              op_q      <= cmd_op;
              remaining <= amt_clamped;
              state     <= ST_SHIFT;
            end else begin
              // Zero-amount shifts fall through here and complete like a NOP.
              if (cmd_op == OP_LOAD)  data <= parallel_in;
              if (cmd_op == OP_CLEAR) data <= '0;
              done <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data       <= step_nxt;
          serial_out <= step_ej;
          remaining  <= remaining - AMT_ONE;
          if (remaining == AMT_ONE) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state == ST_IDLE);
  assign busy         = (state == ST_SHIFT);
  assign parallel_out = data;

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed bench for usr_shift_engine at WIDTH=8; inputs driven and outputs sampled on falling edges.
module tb_usr_shift_engine;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, SAR = 3'b110, CLR = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amount;
  logic       serial_in;
  logic [7:0] parallel_in;
  logic [7:0] parallel_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usr_shift_engine #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_amount   (cmd_amount),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  // Offers one command for a single edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] pin);
    @(negedge clk);
    cmd_op      = op;
    cmd_amount  = amt;
    parallel_in = pin;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_amount = 4'd0;
    serial_in = 1'b0; parallel_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({parallel_out, serial_out, busy, done, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got po=%h so=%b busy=%b done=%b rdy=%b, want 00 0 0 0 1",
               parallel_out, serial_out, busy, done, cmd_ready);
    end
  endtask

  task automatic test_load;
    issue(LOAD, 4'd0, 8'hA5);
    total++;
    if ({parallel_out, done, busy} !== {8'hA5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_a5: got po=%h done=%b busy=%b, want a5 1 0", parallel_out, done, busy);
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL load_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_shl;
    logic [7:0] exp_seq [3] = '{8'h4B, 8'h97, 8'h2F};
    serial_in = 1'b1;
    issue(SHL, 4'd3, 8'h00);
    total++;
    if ({parallel_out, busy, done, cmd_ready} !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL shl_accept: got po=%h busy=%b done=%b rdy=%b, want a5 1 0 0",
               parallel_out, busy, done, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (i < 2) begin
        if ({parallel_out, busy, done} !== {exp_seq[i], 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL shl_step%0d: got po=%h busy=%b done=%b, want %h 1 0",
                   i + 1, parallel_out, busy, done, exp_seq[i]);
        end
      end else if ({parallel_out, serial_out, busy, done, cmd_ready} !==
                   {8'h2F, 1'b1, 1'b0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL shl_done: got po=%h so=%b busy=%b done=%b rdy=%b, want 2f 1 0 1 1",
                 parallel_out, serial_out, busy, done, cmd_ready);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL shl_done_pulse: got done=%b, want 0", done);
    end
    serial_in = 1'b0;
  endtask

  // Loads a start value, runs one shift, counts busy cycles and checks the final state.
  task automatic test_shift_case(input string name, input logic [2:0] op, input logic [3:0] amt,
                                 input logic sin, input logic [7:0] start,
                                 input logic [7:0] exp_val, input logic exp_so, input int exp_busy);
    int n = 0;
    issue(LOAD, 4'd0, start);
    serial_in = sin;
    issue(op, amt, 8'h00);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if ({parallel_out, serial_out, done, cmd_ready} !== {exp_val, exp_so, 1'b1, 1'b1} || n != exp_busy) begin
      bad++;
      $display("FAIL %s: got po=%h so=%b done=%b rdy=%b busy_cycles=%0d, want %h %b 1 1 %0d",
               name, parallel_out, serial_out, done, cmd_ready, n, exp_val, exp_so, exp_busy);
    end
    serial_in = 1'b0;
  endtask

  task automatic test_single_cycle_ops;
    logic so_before;
    so_before = serial_out;
    issue(SHL, 4'd0, 8'h00);
    total++;
    if ({parallel_out, serial_out, done, busy} !== {8'hFF, so_before, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL shl_zero_amount: got po=%h so=%b done=%b busy=%b, want ff %b 1 0",
               parallel_out, serial_out, done, busy, so_before);
    end
    issue(CLR, 4'd0, 8'h00);
    total++;
    if ({parallel_out, serial_out, done} !== {8'h00, so_before, 1'b1}) begin
      bad++;
      $display("FAIL clear: got po=%h so=%b done=%b, want 00 %b 1", parallel_out, serial_out, done, so_before);
    end
    issue(NOP, 4'd0, 8'hEE);
    total++;
    if ({parallel_out, done} !== {8'h00, 1'b1}) begin
      bad++;
      $display("FAIL nop: got po=%h done=%b, want 00 1", parallel_out, done);
    end
  endtask

  task automatic test_reset_mid_shift;
    issue(LOAD, 4'd0, 8'hF0);
    serial_in = 1'b0;
    issue(SHR, 4'd5, 8'h00);
    repeat (2) @(negedge clk);
    total++;
    if ({parallel_out, busy} !== {8'h3C, 1'b1}) begin
      bad++;
      $display("FAIL shr_two_steps: got po=%h busy=%b, want 3c 1", parallel_out, busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({parallel_out, serial_out, busy, done, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_shift_reset: got po=%h so=%b busy=%b done=%b rdy=%b, want 00 0 0 0 1",
               parallel_out, serial_out, busy, done, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(LOAD, 4'd0, 8'h5A);
    total++;
    if ({parallel_out, done, busy} !== {8'h5A, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_after_reset: got po=%h done=%b busy=%b, want 5a 1 0", parallel_out, done, busy);
    end
  endtask

  task automatic test_back_to_back;
    serial_in = 1'b0;
    issue(SHL, 4'd2, 8'h00);
    cmd_op = LOAD; parallel_in = 8'h11; cmd_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({parallel_out, busy, cmd_ready} !== {8'hB4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL held_load_ignored: got po=%h busy=%b rdy=%b, want b4 1 0", parallel_out, busy, cmd_ready);
    end
    @(negedge clk);
    total++;
    if ({parallel_out, done, cmd_ready} !== {8'h68, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_shl_done: got po=%h done=%b rdy=%b, want 68 1 1", parallel_out, done, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({parallel_out, done, busy} !== {8'h11, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_load: got po=%h done=%b busy=%b, want 11 1 0", parallel_out, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_shift_case("ror4_3c", ROR, 4'd4, 1'b0, 8'h3C, 8'hC3, 1'b1, 4);
    test_shift_case("sar9_80", SAR, 4'd9, 1'b0, 8'h80, 8'hFF, 1'b1, 8);
    test_shift_case("rol8_96", ROL, 4'd8, 1'b0, 8'h96, 8'h96, 1'b0, 8);
    test_shift_case("shr15_00", SHR, 4'd15, 1'b1, 8'h00, 8'hFF, 1'b0, 8);
    test_single_cycle_ops();
    test_reset_mid_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_shift_engine.md
# usr_shift_engine

Parametrised universal shift register with a command interface. It is the successor to the fixed 4-bit PIPO register: the width is configurable, and it adds parallel load, clear, logical/arithmetic shifts and rotates by a programmable amount. Multi-bit shifts execute one bit per clock under a small FSM with valid/ready handshake, busy and done. It sits between a register-file/controller and any datapath needing serial or parallel access to a word.

## Interface
- WIDTH, 8, data width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), derived localparam; width of shift amount
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command (high only in IDLE)
- cmd_op  input  3  000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 SAR, 111 CLEAR
- cmd_amount  input  CNT_W  shift count for ops 010–110; values > WIDTH clamp to WIDTH
- serial_in  input  1  fill bit: enters LSB on SHL, MSB on SHR; ignored by other ops
- parallel_in  input  WIDTH  data for LOAD
- parallel_out  output  WIDTH  register contents
- serial_out  output  1  bit ejected by the most recent shift/rotate step
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse on command completion

## Operation
- Accept = rising edge with cmd_valid && cmd_ready; cmd_op, clamped cmd_amount and parallel_in sampled only there.
- FSM states: IDLE, SHIFT. cmd_ready = (state==IDLE); busy = (state==SHIFT).
- IDLE, accept NOP/LOAD/CLEAR, or any shift op with amount 0: completes at the accept edge (LOAD: reg←parallel_in; CLEAR: reg←0; others: no change); done set; stay IDLE.
- IDLE, accept shift op with amount N≥1: latch op, remaining←N, go SHIFT; register unchanged at accept edge.
- SHIFT: each edge performs one step, remaining−1; on the step making remaining 0, go IDLE and set done.
- Step rules: SHL reg←{reg[W-2:0],serial_in}, out←reg[W-1]; SHR reg←{serial_in,reg[W-1:1]}, out←reg[0]; ROL/ROR wrap, out = wrapped bit; SAR MSB replicated, out←reg[0].
- serial_in is sampled live at every step edge.
- serial_out changes only on step edges; LOAD/CLEAR/NOP leave it unchanged.
- Clamp: SHL/SHR by WIDTH → all bits = serial_in history; ROL/ROR by WIDTH → unchanged; SAR by WIDTH → all sign bits.
- cmd_valid while busy: ignored, no effect; the held command is accepted at the first edge where ready=1.
- Reset (any time, including mid-SHIFT): parallel_out=0, serial_out=0, done=0, busy=0, state IDLE, remaining=0, command abandoned.

## Timing
- Reset values: parallel_out 0, serial_out 0, busy 0, done 0, cmd_ready 1.
- Single-cycle ops: result and done visible in the cycle after the accept edge.
- Shift by N≥1: busy for N cycles after accept; final result, done=1, cmd_ready=1 in the cycle after step N (N+1 edges from accept to done).
- done is high for exactly one cycle per command; back-to-back commands are allowed with no bubble: accept is possible in the done cycle.
- All outputs are registered or decoded from the registered state; there is no combinational input→output path.

## Structure
- Package usr_pkg: op-code localparams (OP_NOP…OP_CLEAR) and the FSM state encoding.
- Sub-module usr_step: combinational one-step shifter (op, reg, serial_in → next reg, ejected bit), reused per step.
- Top: FSM, remaining counter, clamp logic, registers.

## Test plan (WIDTH=8)
- Reset, then LOAD 8'hA5 → parallel_out=A5 next cycle, done 1 cycle, busy never high.
- From A5, SHL amount 3, serial_in=1 → A5→4B→97→2F; busy 3 cycles; serial_out=1; done on 4th cycle after accept.
- From 8'h3C, ROR amount 4 → C3; serial_out=1.
- From 8'h80, SAR amount 9 (clamped) → FF after 8 busy cycles.
- SHR amount 5 on 8'hF0, assert reset after 2 steps → all outputs 0, cmd_ready=1; subsequent LOAD 8'h5A → 5A.
- LOAD 8'h11 held valid during a SHL 2 → not accepted until the done cycle, accepted there, parallel_out=11 next cycle.
